// File: rtl/fpu_fp32_div_seq_pkg.sv
// Shared FPU definitions for the sequential FP32 divider.
// Constants, FSM state encoding and operand classes.
package fpu_fp32_div_seq_pkg;

  localparam logic [31:0] FP32_QNAN     = 32'h7FC00000;
  localparam logic [31:0] FP32_PINF     = 32'h7F800000;
  localparam int          FP32_EXP_BIAS = 127;

  localparam logic [4:0]  QBITS   = 5'd25;
  localparam int          LATENCY = 27;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_NORM
  } div_state_t;

  typedef enum logic [1:0] {
    C_ZERO,
    C_NORM,
    C_INF,
    C_NAN
  } fp_class_t;

  function automatic fp_class_t fp_class(
    input logic [7:0]  e,
    input logic [22:0] f
  );
    fp_class_t c;
    if (e == 8'd0)
      c = C_ZERO;
    else if (e != 8'hFF)
      c = C_NORM;
    else if (f == 23'd0)
      c = C_INF;
    else
      c = C_NAN;
    return c;
  endfunction

endpackage

// File: rtl/fpu_fp32_div_classify.sv
// Operand classification and special-case result for the divider.
// Special result and hit flag are latched when an operation is accepted.
module fpu_fp32_div_classify
  import fpu_fp32_div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cap,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        spec_hit,
  output logic [31:0] spec_res
);

  fp_class_t   ca;
  fp_class_t   cb;
  logic        sgn;
  logic        hit_c;
  logic [31:0] res_c;

  assign ca  = fp_class(srca[30:23], srca[22:0]);
  assign cb  = fp_class(srcb[30:23], srcb[22:0]);
  assign sgn = srca[31] ^ srcb[31];

  // Special-case selection, NaN outranks inf outranks zero
  always_comb begin
    hit_c = 1'b1;
    res_c = 32'd0;
    if (ca == C_NAN || cb == C_NAN ||
        (ca == C_ZERO && cb == C_ZERO) ||
        (ca == C_INF && cb == C_INF))
      res_c = FP32_QNAN;
    else if (ca == C_INF || cb == C_ZERO)
      res_c = FP32_PINF | {sgn, 31'd0};
    else if (ca == C_ZERO || cb == C_INF)
      res_c = {sgn, 31'd0};
    else
      hit_c = 1'b0;
  end

  // Latch the special outcome alongside the operands
  always_ff @(posedge clk) begin
    if (reset) begin
      spec_hit <= 1'b0;
      spec_res <= 32'd0;
    end else if (cap) begin
      spec_hit <= hit_c;
      spec_res <= res_c;
    end
  end

endmodule

// File: rtl/fpu_fp32_div_seq.sv
// Iterative FP32 divider, one restoring quotient bit per clock.
// Fixed latency regardless of operand class.
module fpu_fp32_div_seq
  import fpu_fp32_div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_srca,
  input  logic [31:0] i_srcb,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_dst
);

  div_state_t  state;
  div_state_t  nstate;
  logic [4:0]  count;
  logic [25:0] r;
  logic [25:0] d;
  logic [24:0] q;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic        sgn;
  logic        accept;
  logic        ge;
  logic [25:0] rsel;
  logic [25:0] rnext;
  logic [9:0]  e;
  logic [22:0] mant;
  logic        ovf;
  logic        unf;
  logic [31:0] res_norm;
  logic [31:0] result;
  logic        spec_hit;
  logic [31:0] spec_res;

  assign o_busy = (state != S_IDLE) | o_valid;
  assign accept = i_start & ~o_busy;

  fpu_fp32_div_classify u_cls (
    .clk      (clk),
    .reset    (reset),
    .cap      (accept),
    .srca     (i_srca),
    .srcb     (i_srcb),
    .spec_hit (spec_hit),
    .spec_res (spec_res)
  );

  assign ge    = (r >= d);
  assign rsel  = ge ? (r - d) : r;
  assign rnext = {rsel[24:0], 1'b0};

  assign e = 10'(ea) - 10'(eb)
           + 10'(FP32_EXP_BIAS - 1)
           + 10'(q[24]);
  assign mant = q[24] ? q[23:1] : q[22:0];
  assign ovf  = ~e[9] & (e[8:0] >= 9'd255);
  assign unf  = e[9] | (e == 10'd0);

  // Normalised result with overflow to inf and flush to zero
  always_comb begin
    res_norm = {sgn, e[7:0], mant};
    if (ovf)
      res_norm = FP32_PINF | {sgn, 31'd0};
    else if (unf)
      res_norm = {sgn, 31'd0};
    result = spec_hit ? spec_res : res_norm;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: if (accept) nstate = S_ITER;
      S_ITER: if (count == 5'd1) nstate = S_NORM;
      S_NORM: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Operand capture, quotient iteration and result load
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 5'd0;
      r       <= 26'd0;
      d       <= 26'd0;
      q       <= 25'd0;
      ea      <= 8'd0;
      eb      <= 8'd0;
      sgn     <= 1'b0;
      o_valid <= 1'b0;
      o_dst   <= 32'd0;
    end else begin
      o_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            r     <= {2'b01, i_srca[22:0]};
            d     <= {2'b01, i_srcb[22:0]};
            q     <= 25'd0;
            count <= QBITS;
            ea    <= i_srca[30:23];
            eb    <= i_srcb[30:23];
            sgn   <= i_srca[31] ^ i_srcb[31];
          end
        end
        S_ITER: begin
          q     <= {q[23:0], ge};
          r     <= rnext;
          count <= count - 5'd1;
        end
        S_NORM: begin
          o_dst   <= result;
          o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_fp32_div_seq.sv
// Testbench for fpu_fp32_div_seq.
// Directed and random operations against a truncating division model.
module tb_fpu_fp32_div_seq;

  localparam int LAT = 27;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic [31:0] i_srca;
  logic [31:0] i_srcb;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_dst;

  int errors;
  int checks;

  fpu_fp32_div_seq dut (
    .clk     (clk),
    .reset   (reset),
    .i_start (i_start),
    .i_srca  (i_srca),
    .i_srcb  (i_srcb),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_dst   (o_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quotient from integer division of the significands, truncated
  function automatic logic [31:0] ref_div(
    input logic [31:0] a,
    input logic [31:0] b
  );
    int     xa, xb, ex;
    longint na, nb, qt;
    logic   s, za, zb, ia, ib, nna, nnb;
    logic [31:0] res;
    xa  = int'(a[30:23]);
    xb  = int'(b[30:23]);
    s   = a[31] ^ b[31];
    za  = (xa == 0);
    zb  = (xb == 0);
    ia  = (xa == 255) && (a[22:0] == 0);
    ib  = (xb == 255) && (b[22:0] == 0);
    nna = (xa == 255) && (a[22:0] != 0);
    nnb = (xb == 255) && (b[22:0] != 0);
    if (nna || nnb || (za && zb) || (ia && ib))
      return 32'h7FC00000;
    if (ia || zb)
      return {s, 8'hFF, 23'd0};
    if (za || ib)
      return {s, 31'd0};
    na = longint'({1'b1, a[22:0]});
    nb = longint'({1'b1, b[22:0]});
    if (na >= nb) begin
      qt = (na << 23) / nb;
      ex = xa - xb + 127;
    end else begin
      qt = (na << 24) / nb;
      ex = xa - xb + 126;
    end
    if (ex >= 255)
      return {s, 8'hFF, 23'd0};
    if (ex <= 0)
      return {s, 31'd0};
    res = {s, ex[7:0], qt[22:0]};
    return res;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation; valid must land on the 26th edge after accept,
  // i.e. it occupies the 27th cycle counted from the accept cycle.
  task automatic do_op(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] expv
  );
    int n;
    @(negedge clk);
    i_start = 1'b1;
    i_srca  = a;
    i_srcb  = b;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    chk({tag, ".busy"}, {31'd0, o_busy}, 32'd1);
    n = 0;
    while (o_valid !== 1'b1 && n < 2 * LAT) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".lat"}, n, LAT - 1);
    chk({tag, ".dst"}, o_dst, expv);
    @(posedge clk);
    #1;
    chk({tag, ".vld_off"}, {31'd0, o_valid}, 32'd0);
    chk({tag, ".idle"}, {31'd0, o_busy}, 32'd0);
    chk({tag, ".hold"}, o_dst, expv);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0)
      v[30:23] = 8'd0;
    else if (k == 1)
      v[30:23] = 8'hFF;
    else if (k == 2)
      v[22:0] = 23'd0;
    else if (k < 10)
      v[30:23] = 8'(96 + $urandom_range(0, 63));
    return v;
  endfunction

  initial begin
    int          n;
    int          nv;
    logic [31:0] a;
    logic [31:0] b;

    errors  = 0;
    checks  = 0;
    reset   = 1'b1;
    i_start = 1'b0;
    i_srca  = 32'd0;
    i_srcb  = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", {31'd0, o_busy}, 32'd0);
    chk("rst.valid", {31'd0, o_valid}, 32'd0);
    chk("rst.dst", o_dst, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("6div2", 32'h40C00000, 32'h40000000, 32'h40400000);
    do_op("1div3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
    do_op("m1div3", 32'hBF800000, 32'h40400000, 32'hBEAAAAAA);
    do_op("1div0", 32'h3F800000, 32'h00000000, 32'h7F800000);
    do_op("m1divp0", 32'hBF800000, 32'h00000000, 32'hFF800000);
    do_op("0div0", 32'h00000000, 32'h00000000, 32'h7FC00000);
    do_op("infdivinf", 32'h7F800000, 32'h7F800000, 32'h7FC00000);
    do_op("1divinf", 32'h3F800000, 32'h7F800000, 32'h00000000);
    do_op("nan", 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    do_op("ovf", 32'h7F000000, 32'h3E800000, 32'h7F800000);
    do_op("unf", 32'h00800000, 32'h40000000, 32'h00000000);

    // Starts while busy and in the valid cycle are dropped
    @(negedge clk);
    i_start = 1'b1;
    i_srca  = 32'h40C00000;
    i_srcb  = 32'h40000000;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    i_start = 1'b1;
    i_srca  = 32'h3F800000;
    i_srcb  = 32'h40400000;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    n = 5;
    while (o_valid !== 1'b1 && n < 2 * LAT) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ign.lat", n, LAT - 1);
    chk("ign.dst", o_dst, 32'h40400000);
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    chk("ign.vld_off", {31'd0, o_valid}, 32'd0);
    chk("ign.idle", {31'd0, o_busy}, 32'd0);
    chk("ign.hold", o_dst, 32'h40400000);
    do_op("reacc", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA);

    // Reset in the middle of an operation
    @(negedge clk);
    i_start = 1'b1;
    i_srca  = 32'h40C00000;
    i_srcb  = 32'h40000000;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.busy", {31'd0, o_busy}, 32'd0);
    chk("abort.valid", {31'd0, o_valid}, 32'd0);
    chk("abort.dst", o_dst, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nv = 0;
    repeat (2 * LAT) begin
      @(posedge clk);
      #1;
      if (o_valid === 1'b1) nv++;
    end
    chk("abort.novalid", nv, 0);
    do_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000);

    // Random operands against the model
    for (int i = 0; i < 40; i++) begin
      a = rnd_fp();
      b = rnd_fp();
      do_op($sformatf("rnd%0d", i), a, b, ref_div(a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
